// File: rtl/sr_sched_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sr_sched_pkg: shared types for the SR flag scheduler             |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package sr_sched_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_CLR = 2'b01,
    OP_SET = 2'b10,
    OP_TGL = 2'b11
  } sr_op_e;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arbiter: round-robin grant, scan starts at the rotating ptr   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          adv,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_scan;
  logic          w_found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_scan  = '0;
    for (int k = 0; k < N; k++) begin
      w_scan = PW'((int'(r_ptr) + k) % N);
      if (!w_found && req[w_scan]) begin
        w_found      = 1'b1;
        gnt[w_scan]  = 1'b1;
        gnt_idx      = w_scan;
      end
    end
  end

  // Pointer moves just past the winner so it has lowest priority next time.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (adv) begin
      r_ptr <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/sr_flag_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sr_flag_scheduler: arbitrates set/clear/toggle commands onto a   |
// | bank of reset-less SR flops, never driving S=R=1.                |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module sr_flag_scheduler
  import sr_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IDXW  = $clog2(NFLAG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [IDXW*NREQ-1:0] req_idx,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 clr_all,
  output logic [NFLAG-1:0]     s_out,
  output logic [NFLAG-1:0]     r_out,
  output logic [NFLAG-1:0]     flag_q,
  output logic                 busy,
  output logic                 err
);

  localparam int               c_pw    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDXW:0]    c_nflag = NFLAG[IDXW:0];
  localparam logic [NFLAG-1:0] c_one   = {{(NFLAG-1){1'b0}}, 1'b1};

  sched_state_e      r_state, w_state_nxt;
  logic [NREQ-1:0]   w_req, w_gnt;
  logic [c_pw-1:0]   w_gnt_idx;
  logic              w_xfer, w_idx_bad, w_err_nxt;
  sr_op_e            w_op;
  logic [IDXW-1:0]   w_idx;
  logic [NFLAG-1:0]  w_eff, w_sel, w_s_nxt, w_r_nxt;

  assign w_req     = (r_state == RUN && !clr_all) ? req_valid : '0;
  assign req_ready = w_gnt;
  assign w_xfer    = |w_gnt;
  assign busy      = (r_state == INIT);

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (w_req),
    .adv     (w_xfer),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  always_comb begin
    w_op  = OP_NOP;
    w_idx = '0;
    for (int g = 0; g < NREQ; g++) begin
      if (w_gnt_idx == c_pw'(g)) begin
        w_op  = sr_op_e'(req_op[2*g +: 2]);
        w_idx = req_idx[IDXW*g +: IDXW];
      end
    end
  end

  // Flag value once the pulse currently on s_out/r_out has landed.
  assign w_eff     = (flag_q & ~r_out) | s_out;
  assign w_sel     = c_one << w_idx;
  assign w_idx_bad = ({1'b0, w_idx} >= c_nflag);

  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = '0;
    w_r_nxt     = '0;
    w_err_nxt   = 1'b0;
    case (r_state)
      INIT: w_state_nxt = RUN;
      RUN: begin
        if (clr_all) begin
          w_r_nxt = '1;
        end else if (w_xfer) begin
          if (w_idx_bad) begin
            w_err_nxt = 1'b1;
          end else begin
            case (w_op)
              OP_SET: w_s_nxt = w_sel;
              OP_CLR: w_r_nxt = w_sel;
              OP_TGL: begin
                if (|(w_eff & w_sel)) w_r_nxt = w_sel;
                else                  w_s_nxt = w_sel;
              end
              default: ;
            endcase
          end
        end
      end
      default: w_state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= INIT;
    else     r_state <= w_state_nxt;
  end

  // Shadow follows the bank: it samples s_out/r_out at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_out  <= '0;
      r_out  <= '1;
      flag_q <= '0;
      err    <= 1'b0;
    end else begin
      s_out  <= w_s_nxt;
      r_out  <= w_r_nxt;
      flag_q <= (flag_q & ~r_out) | s_out;
      err    <= w_err_nxt;
    end
  end

endmodule
`default_nettype wire
